// File: rtl/video_pingpong_fb.sv
// video_pingpong_fb: double-buffered frame store between the serial video
// receiver and the VGA controller. Serial bits are packed MSB-first into
// BPP-bit pixels and written to the back bank. The front bank is read at the
// scaled scan position. Banks swap only at VGA frame end, and only once a
// complete back frame exists, so the display never tears.
// Optional feature macro: VIDEO_FB_CHECKERBOARD_EN. When defined, a
// checkerboard is shown before the first swap. When undefined, the startup
// image is all-ones (white).
module video_pingpong_fb #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 628,
  parameter int SCALE    = 4,
  parameter int BPP      = 1,
  localparam int XW = $clog2(H_TOTAL),
  localparam int YW = $clog2(V_TOTAL)
) (
  input  logic           CLK_40,
  input  logic           reset,
  input  logic           bit_valid,
  input  logic           bit_in,
  input  logic           frame_start,
  input  logic [XW-1:0]  vga_x,
  input  logic [YW-1:0]  vga_y,
  input  logic           vga_active,
  input  logic           vga_frame_end,
  output logic [BPP-1:0] pixel_out,
  output logic           pixel_valid,
  output logic           frame_ready,
  output logic           display_bank,
  output logic           overflow
);

  localparam int X_W   = H_ACTIVE / SCALE;
  localparam int Y_H   = V_ACTIVE / SCALE;
  localparam int DEPTH = X_W * Y_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int SL    = $clog2(SCALE);
  localparam int CW    = (BPP > 1) ? $clog2(BPP) : 1;

  // Refuse to build with a scale that cannot be done by shifting, or a bad depth
  generate
    if (SCALE < 1 || (SCALE & (SCALE - 1)) != 0) begin : g_bad_scale
      $error("video_pingpong_fb: SCALE must be a power of two");
    end
    if (BPP < 1 || BPP > 8) begin : g_bad_bpp
      $error("video_pingpong_fb: BPP must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BPP-1:0] shift_q, shift_d;
  logic           display_bank_q, display_bank_d;
  logic           overflow_q, overflow_d;
  logic           swapped_q, swapped_d;
  logic           pixel_valid_q, pixel_valid_d;
  logic           use_ram_q, use_ram_d;
  logic [BPP-1:0] pattern_q, pattern_d;
  logic [BPP-1:0] rd_data_q;

  logic [BPP-1:0] mem [0:1][0:DEPTH-1];

  logic [BPP-1:0] packed_pix;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  cur_ptr;
  logic [CW-1:0]  cur_cnt;
  logic [XW-1:0]  xs;
  logic [YW-1:0]  ys;
  logic [AW-1:0]  rd_addr;

  // The newest bit enters at the LSB, so after BPP bits the first bit is the MSB
  assign packed_pix = BPP'({shift_q, bit_in});

  assign xs      = vga_x >> SL;
  assign ys      = vga_y >> SL;
  assign rd_addr = AW'(32'(ys) * X_W + 32'(xs));

  // Write-side sequencing: pixel packing, restart handling, overflow and bank swap
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    display_bank_d = display_bank_q;
    overflow_d     = overflow_q;
    swapped_d      = swapped_q;
    wr_en          = 1'b0;
    wr_addr        = ptr_q;
    cur_ptr        = ptr_q;
    cur_cnt        = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = FILL;
          ptr_d     = '0;
          bit_cnt_d = '0;
        end
      end
      FILL: begin
        if (frame_start) begin
          cur_ptr   = '0;
          cur_cnt   = '0;
          ptr_d     = '0;
          bit_cnt_d = '0;
        end
        if (bit_valid) begin
          shift_d = packed_pix;
          if (cur_cnt == CW'(BPP - 1)) begin
            wr_en     = 1'b1;
            wr_addr   = cur_ptr;
            bit_cnt_d = '0;
            ptr_d     = cur_ptr + AW'(1);
            if (cur_ptr == AW'(DEPTH - 1)) begin
              state_d = FULL;
            end
          end else begin
            bit_cnt_d = cur_cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (bit_valid) begin
          overflow_d = 1'b1;
        end
        if (vga_frame_end) begin
          display_bank_d = ~display_bank_q;
          swapped_d      = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-side request for next cycle: visibility, source select and startup image
  always_comb begin
    pixel_valid_d = vga_active;
    use_ram_d     = swapped_q;
`ifdef VIDEO_FB_CHECKERBOARD_EN
    pattern_d     = {BPP{xs[0] ^ ys[0]}};
`else
    pattern_d     = '1;
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK_40) begin
    if (!reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      display_bank_q <= 1'b0;
      overflow_q     <= 1'b0;
      swapped_q      <= 1'b0;
      pixel_valid_q  <= 1'b0;
      use_ram_q      <= 1'b0;
      pattern_q      <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      display_bank_q <= display_bank_d;
      overflow_q     <= overflow_d;
      swapped_q      <= swapped_d;
      pixel_valid_q  <= pixel_valid_d;
      use_ram_q      <= use_ram_d;
      pattern_q      <= pattern_d;
    end
  end

  // Bank RAMs: write into the back bank, synchronous read of the front bank
  always_ff @(posedge CLK_40) begin
    if (wr_en) begin
      mem[~display_bank_q][wr_addr] <= packed_pix;
    end
    if (vga_active) begin
      rd_data_q <= mem[display_bank_q][rd_addr];
    end
  end

  assign pixel_out    = pixel_valid_q ? (use_ram_q ? rd_data_q : pattern_q) : '0;
  assign pixel_valid  = pixel_valid_q;
  assign frame_ready  = (state_q == FULL);
  assign display_bank = display_bank_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_video_pingpong_fb.sv
// tb_video_pingpong_fb: randomized bench for video_pingpong_fb. A free-running
// scan generator and serial bit driver feed the design; a frame-level model
// (queue of received bits, last completed frame, displayed frame) predicts
// every output each cycle.
`timescale 1ns/1ps
module tb_video_pingpong_fb;

  localparam int H_ACTIVE = 32;
  localparam int V_ACTIVE = 24;
  localparam int H_TOTAL  = 40;
  localparam int V_TOTAL  = 32;
  localparam int SCALE    = 4;
  localparam int BPP      = 2;
  localparam int X_W      = H_ACTIVE / SCALE;
  localparam int DEPTH    = X_W * (V_ACTIVE / SCALE);
  localparam int NBITS    = DEPTH * BPP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       frame_start = 1'b0;
  logic [5:0] vga_x = '0;
  logic [4:0] vga_y = '0;
  logic       vga_active = 1'b0;
  logic       vga_frame_end = 1'b0;
  logic [1:0] pixel_out;
  logic       pixel_valid;
  logic       frame_ready;
  logic       display_bank;
  logic       overflow;

  video_pingpong_fb #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL), .SCALE(SCALE), .BPP(BPP)
  ) dut (
    .CLK_40(clk),
    .reset(rst_n),
    .bit_valid(bit_valid),
    .bit_in(bit_in),
    .frame_start(frame_start),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_active(vga_active),
    .vga_frame_end(vga_frame_end),
    .pixel_out(pixel_out),
    .pixel_valid(pixel_valid),
    .frame_ready(frame_ready),
    .display_bank(display_bank),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int sx = 0;
  int sy = 0;
  bit m_receiving = 1'b0;
  bit m_ready = 1'b0;
  bit m_swapped = 1'b0;
  bit m_disp = 1'b0;
  bit m_ovf = 1'b0;
  bit m_bits[$];
  int m_front[DEPTH];
  int m_done[DEPTH];
  int tx_pix[DEPTH];

  task automatic checkOutput(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at t=%0t scan=(%0d,%0d): got %0d expected %0d",
               tag, $time, sx, sy, got, exp);
    end
  endtask

  function automatic int startupPixel(input int x, input int y);
`ifdef VIDEO_FB_CHECKERBOARD_EN
    return ((((x / SCALE) + (y / SCALE)) % 2) == 1) ? 3 : 0;
`else
    return 3;
`endif
  endfunction

  task automatic modelReset();
    m_receiving = 1'b0;
    m_ready     = 1'b0;
    m_swapped   = 1'b0;
    m_disp      = 1'b0;
    m_ovf       = 1'b0;
    m_bits.delete();
  endtask

  task automatic modelStep(input bit bv, input bit bi, input bit fs, input bit fe);
    if (m_ready) begin
      if (bv) m_ovf = 1'b1;
      if (fe) begin
        m_ready   = 1'b0;
        m_disp    = !m_disp;
        m_swapped = 1'b1;
        m_front   = m_done;
      end
    end else if (m_receiving) begin
      if (fs) m_bits.delete();
      if (bv) begin
        m_bits.push_back(bi);
        if (m_bits.size() == NBITS) begin
          for (int p = 0; p < DEPTH; p++)
            m_done[p] = 2 * int'(m_bits[2*p]) + int'(m_bits[2*p+1]);
          m_ready     = 1'b1;
          m_receiving = 1'b0;
          m_bits.delete();
        end
      end
    end else if (fs) begin
      m_receiving = 1'b1;
      m_bits.delete();
    end
  endtask

  task automatic applyStimulus(input bit bv, input bit bi, input bit fs, input bit fe);
    int  exp_pix;
    int  exp_valid;
    bit  act;
    act           = (sx < H_ACTIVE) && (sy < V_ACTIVE);
    bit_valid     = bv;
    bit_in        = bi;
    frame_start   = fs;
    vga_frame_end = fe;
    vga_x         = 6'(sx);
    vga_y         = 5'(sy);
    vga_active    = act;
    if (!rst_n || !act) begin
      exp_valid = 0;
      exp_pix   = 0;
    end else begin
      exp_valid = 1;
      exp_pix   = m_swapped ? m_front[(sy / SCALE) * X_W + sx / SCALE] : startupPixel(sx, sy);
    end
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(bv, bi, fs, fe);
    #1;
    checkOutput("pixel_valid", int'(pixel_valid), exp_valid);
    checkOutput("pixel_out", int'(pixel_out), exp_pix);
    checkOutput("frame_ready", int'(frame_ready), int'(m_ready));
    checkOutput("display_bank", int'(display_bank), int'(m_disp));
    checkOutput("overflow", int'(overflow), int'(m_ovf));
    sx++;
    if (sx == H_TOTAL) begin
      sx = 0;
      sy++;
      if (sy == V_TOTAL) sy = 0;
    end
  endtask

  task automatic idleCycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise && ($urandom_range(0, 3) == 0))
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic sendBits(input int first, input int last, input bit fe_on_last);
    bit b;
    for (int k = first; k <= last; k++) begin
      idleCycles($urandom_range(0, 2), 1'b0);
      b = 1'((tx_pix[k / BPP] >> (BPP - 1 - (k % BPP))) & 1);
      applyStimulus(1'b1, b, 1'b0, fe_on_last && (k == last));
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleCycles(3, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic randomFrame();
    for (int i = 0; i < DEPTH; i++) tx_pix[i] = $urandom_range(0, 3);
  endtask

  initial begin
    // Startup image and blanking after reset, with stray bits while idle
    doReset();
    idleCycles(H_TOTAL * V_TOTAL, 1'b1);

    // Frame with pixel i = i mod 4, swapped in and scanned
    for (int i = 0; i < DEPTH; i++) tx_pix[i] = i % 4;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(0, NBITS - 1, 1'b0);
    idleCycles(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(H_TOTAL * V_TOTAL, 1'b1);

    // Complete frame followed by extra bits and an ignored frame_start
    randomFrame();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(0, NBITS - 1, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(H_TOTAL * V_TOTAL, 1'b0);

    // Partial frame aborted by a restart that coincides with the new first bit
    doReset();
    idleCycles(50, 1'b1);
    randomFrame();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(0, 39, 1'b0);
    for (int i = 0; i < DEPTH; i++) tx_pix[i] = 1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    sendBits(1, NBITS - 1, 1'b0);
    idleCycles(4, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(H_TOTAL * V_TOTAL, 1'b1);

    // Final write coinciding with frame end: swap deferred to the next frame end
    randomFrame();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(0, NBITS - 1, 1'b1);
    idleCycles(5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(H_TOTAL * V_TOTAL, 1'b1);

    // Reset while a full frame is pending: back to the startup image
    randomFrame();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    sendBits(0, NBITS - 1, 1'b0);
    idleCycles(3, 1'b0);
    doReset();
    idleCycles(H_TOTAL * V_TOTAL, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
